// File: rtl/fft_outseq_pkg.sv
// Shared types and default constants for the FFT output sequencer.
package fft_outseq_pkg;

    localparam int unsigned LOG2N_DEF   = 6;
    localparam int unsigned FRAME_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/fft_output_sequencer_if.sv
// Handshake bundle between the FFT output sequencer and its consumer.
// Macro FFT_OUTSEQ_BITREV_EN adds the bit-reversed buffer address addr_o.
interface fft_output_sequencer_if #(
    parameter int unsigned LOG2N   = fft_outseq_pkg::LOG2N_DEF,
    parameter int unsigned FRAME_W = fft_outseq_pkg::FRAME_W_DEF
);

    logic               start;
    logic               ready;
    logic [LOG2N-1:0]   index_o;
    logic               valid_o;
    logic               last_o;
    logic               busy_o;
    logic [FRAME_W-1:0] frame_cnt_o;
    logic               overrun_o;
`ifdef FFT_OUTSEQ_BITREV_EN
    logic [LOG2N-1:0]   addr_o;
`endif

    // Sequencer side
    modport master (
`ifdef FFT_OUTSEQ_BITREV_EN
        output addr_o,
`endif
        input  start,
        input  ready,
        output index_o,
        output valid_o,
        output last_o,
        output busy_o,
        output frame_cnt_o,
        output overrun_o
    );

    // FFT core / downstream side
    modport slave (
`ifdef FFT_OUTSEQ_BITREV_EN
        input  addr_o,
`endif
        output start,
        output ready,
        input  index_o,
        input  valid_o,
        input  last_o,
        input  busy_o,
        input  frame_cnt_o,
        input  overrun_o
    );

endinterface

// File: rtl/bitrev_idx.sv
// Combinational W-bit reversal, used to turn a natural-order index into a
// bit-reversed buffer address.
module bitrev_idx #(
    parameter int unsigned W = 6
) (
    input  logic [W-1:0] in_idx,
    output logic [W-1:0] out_idx
);

    // Mirror bit i onto bit W-1-i
    always_comb begin
        out_idx = '0;
        for (int i = 0; i < int'(W); i++) begin
            out_idx[i] = in_idx[W-1-i];
        end
    end

endmodule

// File: rtl/fft_output_sequencer.sv
// FFT output sequencer: streams natural-order indices 0..N-1 per frame with
// valid/ready backpressure, counts completed frames, flags dropped starts.
// Optional macro FFT_OUTSEQ_BITREV_EN adds a registered bit-reversed addr_o.
module fft_output_sequencer
    import fft_outseq_pkg::*;
#(
    parameter int unsigned LOG2N   = LOG2N_DEF,
    parameter int unsigned FRAME_W = FRAME_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    fft_output_sequencer_if.master bus
);

    localparam logic [LOG2N-1:0] IDX_MAX = {LOG2N{1'b1}};

    seq_state_e         state_q, state_d;
    logic [LOG2N-1:0]   idx_q,   idx_d;
    logic [FRAME_W-1:0] cnt_q,   cnt_d;
    logic               valid_q, valid_d;
    logic               last_q,  last_d;
    logic               ovr_q,   ovr_d;
    logic               accept;
    logic               last_acc;

`ifdef FFT_OUTSEQ_BITREV_EN
    logic [LOG2N-1:0]   addr_q, addr_d;

    // Address follows the next index so it lands in the same cycle as index_o
    bitrev_idx #(.W(LOG2N)) u_bitrev (
        .in_idx  (idx_d),
        .out_idx (addr_d)
    );
`endif

    // Next-state, next-index, frame counting and overrun detection
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ovr_d    = 1'b0;
        accept   = (state_q == RUN) && bus.ready;
        last_acc = accept && (idx_q == IDX_MAX);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                // A start only launches a frame on the accepted last beat
                ovr_d = bus.start && !last_acc;
                if (accept) begin
                    if (idx_q == IDX_MAX) begin
                        cnt_d = cnt_q + FRAME_W'(1);
                        idx_d = '0;
                        if (!bus.start) begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + LOG2N'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        valid_d = (state_d == RUN);
        last_d  = valid_d && (idx_d == IDX_MAX);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef FFT_OUTSEQ_BITREV_EN
    // Bit-reversed read address register
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign bus.addr_o = addr_q;
`endif

    assign bus.index_o     = idx_q;
    assign bus.valid_o     = valid_q;
    assign bus.last_o      = last_q;
    assign bus.busy_o      = valid_q;
    assign bus.frame_cnt_o = cnt_q;
    assign bus.overrun_o   = ovr_q;

endmodule

// File: tb/tb_fft_output_sequencer.sv
// Self-checking bench for fft_output_sequencer (LOG2N=6, FRAME_W=2):
// directed scenarios followed by random start/ready/rst traffic, all
// compared cycle by cycle against a beat-counting reference model.
module tb_fft_output_sequencer;

    localparam int unsigned LOG2N   = 6;
    localparam int unsigned FRAME_W = 2;
    localparam int          N       = 1 << LOG2N;
    localparam int          FMOD    = 1 << FRAME_W;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame activity, beat position, completed frames
    bit m_active;
    int m_pos;
    int m_frames;
    bit m_ovr;

    fft_output_sequencer_if #(.LOG2N(LOG2N), .FRAME_W(FRAME_W)) bus ();

    fft_output_sequencer #(.LOG2N(LOG2N), .FRAME_W(FRAME_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int k = 0; k < int'(LOG2N); k++) begin
            r = r * 2 + ((v >> k) & 1);
        end
        return r;
    endfunction

    // Advance the model by one clock edge with the given inputs
    task automatic model_step(input bit s, input bit r, input bit rs);
        if (rs) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_frames = 0;
            m_ovr    = 1'b0;
        end else if (!m_active) begin
            m_ovr = 1'b0;
            if (s) begin
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else begin
            m_ovr = s && !(r && m_pos == N - 1);
            if (r) begin
                if (m_pos == N - 1) begin
                    m_frames = (m_frames + 1) % FMOD;
                    m_pos    = 0;
                    m_active = s;
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("valid",   32'(bus.valid_o),     32'(m_active));
        check("busy",    32'(bus.busy_o),      32'(m_active));
        check("index",   32'(bus.index_o),     32'(m_pos));
        check("last",    32'(bus.last_o),      32'(m_active && m_pos == N - 1));
        check("frames",  32'(bus.frame_cnt_o), 32'(m_frames));
        check("overrun", 32'(bus.overrun_o),   32'(m_ovr));
`ifdef FFT_OUTSEQ_BITREV_EN
        check("addr",    32'(bus.addr_o),      32'(bitrev(m_pos)));
`endif
    endtask

    // Inputs applied at the falling edge, outputs checked at the next one
    task automatic cycle(input bit s, input bit r, input bit rs);
        bus.start = s;
        bus.ready = r;
        rst       = rs;
        @(posedge clk);
        model_step(s, r, rs);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int first_last;
        int busy_drops;
        int f_exp[5] = '{1, 2, 3, 0, 1};

        bus.start = 1'b0;
        bus.ready = 1'b0;
        rst       = 1'b1;
        m_active  = 1'b0;
        m_pos     = 0;
        m_frames  = 0;
        m_ovr     = 1'b0;
        @(negedge clk);

        // Reset, and reset winning over a simultaneous start
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);

        // One full frame with ready always high
        first_last = -1;
        for (int j = 0; j < 66; j++) begin
            cycle(j == 0, 1'b1, 1'b0);
            if (bus.last_o && first_last < 0) first_last = j + 1;
        end
        check("a_last_cycle", 32'(first_last), 32'd64);
        check("a_frame_cnt", 32'(bus.frame_cnt_o), 32'd1);

        // Backpressure during cycles 10..14
        cycle(1'b0, 1'b1, 1'b1);
        first_last = -1;
        for (int j = 0; j < 72; j++) begin
            cycle(j == 0, !(j >= 10 && j <= 14), 1'b0);
            if (j == 12) check("b_hold", 32'(bus.index_o), 32'd9);
            if (bus.last_o && first_last < 0) first_last = j + 1;
        end
        check("b_last_cycle", 32'(first_last), 32'd69);

        // Back-to-back frames: start on the accepted last beat
        cycle(1'b0, 1'b1, 1'b1);
        busy_drops = 0;
        for (int j = 0; j < 130; j++) begin
            cycle(j == 0 || j == 64, 1'b1, 1'b0);
            if (j < 128 && !bus.busy_o) busy_drops++;
            if (j == 63) check("c_idx63", 32'(bus.index_o), 32'd63);
            if (j == 64) check("c_idx0", 32'(bus.index_o), 32'd0);
        end
        check("c_busy_drops", 32'(busy_drops), 32'd0);
        check("c_frame_cnt", 32'(bus.frame_cnt_o), 32'd2);

        // Dropped start at index 20
        cycle(1'b0, 1'b1, 1'b1);
        for (int j = 0; j < 70; j++) begin
            cycle(j == 0 || j == 21, 1'b1, 1'b0);
            if (j == 21) check("d_ovr_hi", 32'(bus.overrun_o), 32'd1);
            if (j == 22) check("d_ovr_lo", 32'(bus.overrun_o), 32'd0);
            if (j == 22) check("d_idx", 32'(bus.index_o), 32'd22);
        end
        check("d_frame_cnt", 32'(bus.frame_cnt_o), 32'd1);

        // Reset mid-frame at index 30, then restart
        cycle(1'b0, 1'b1, 1'b1);
        for (int j = 0; j < 40; j++) begin
            cycle(j == 0 || j == 35, 1'b1, j == 31);
            if (j == 31) check("e_valid", 32'(bus.valid_o), 32'd0);
            if (j == 31) check("e_frames", 32'(bus.frame_cnt_o), 32'd0);
            if (j == 35) check("e_restart", 32'(bus.index_o), 32'd0);
        end

        // Five frames with a 2-bit frame counter
        cycle(1'b0, 1'b1, 1'b1);
        for (int f = 0; f < 5; f++) begin
            for (int j = 0; j < 66; j++) begin
                cycle(j == 0, 1'b1, 1'b0);
            end
            check("f_frame_cnt", 32'(bus.frame_cnt_o), 32'(f_exp[f]));
        end

        // Random traffic
        for (int j = 0; j < 3000; j++) begin
            cycle($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 75,
                  $urandom_range(0, 999) < 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_output_sequencer.md
FFT_OUTPUT_SEQUENCER -- requirements
Module: fft_output_sequencer

Interface
REQ-001 Parameter LOG2N, default 6: log2 of FFT points per frame; N = 2**LOG2N, legal range 2..12.
REQ-002 Parameter FRAME_W, default 8: width of the completed-frame counter.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  frame-available strobe from the FFT core; one cycle per frame.
REQ-006 ready  in  1  downstream accept; a beat transfers when valid_o && ready.
REQ-007 index_o  out  LOG2N  natural-order output index of the current beat.
REQ-008 valid_o  out  1  current beat valid.
REQ-009 last_o  out  1  high with valid_o when index_o == N-1.
REQ-010 busy_o  out  1  high while in RUN.
REQ-011 frame_cnt_o  out  FRAME_W  count of completed frames, wraps modulo 2**FRAME_W.
REQ-012 overrun_o  out  1  one-cycle pulse when start is dropped.

Function
REQ-013 States: IDLE, RUN; all outputs registered, no combinational input-to-output path.
REQ-014 IDLE: valid_o=0, busy_o=0, index_o=0; start=1 at edge t -> RUN, valid_o=1, index_o=0 from t+1 (latency 1).
REQ-015 RUN: valid_o=1 every cycle; index_o holds while ready=0, increments by 1 on each accepted beat.
REQ-016 Accepted beat with index_o==N-1: frame_cnt_o increments (wraps all-ones -> 0 with no flag).
REQ-017 Last beat accepted with start=1 the same cycle: stays RUN, index_o=0 next cycle, no idle gap.
REQ-018 Last beat accepted with start=0: -> IDLE, valid_o=0 next cycle.
REQ-019 start=1 in RUN outside the accepted-last-beat cycle: ignored, overrun_o=1 for exactly the next cycle, frame unaffected.
REQ-020 start is not latched; a start held for several cycles in IDLE launches one frame, the further cycles count as overruns.
REQ-021 last_o and index_o are stable while ready=0 (no beat lost or duplicated under backpressure).

Reset
REQ-022 rst=1 at an edge: state IDLE, index_o=0, valid_o=0, last_o=0, busy_o=0, overrun_o=0, frame_cnt_o=0; rst has priority over start.
REQ-023 Reset mid-frame aborts the frame: no last_o, no frame_cnt_o increment; next start begins at index 0.

Configuration
REQ-024 Macro FFT_OUTSEQ_BITREV_EN defined: extra output addr_o (LOG2N) = bit-reversed index_o, registered and aligned with index_o, for direct buffer read addressing.
REQ-025 Macro not defined: addr_o port and bit-reverse logic absent; all other behaviour identical.

Structure
REQ-026 Package fft_outseq_pkg holds the state enum typedef (IDLE, RUN) and default constants LOG2N_DEF=6, FRAME_W_DEF=8.
REQ-027 Sub-module bitrev_idx (parameter W, combinational W-bit reversal) instantiated only under FFT_OUTSEQ_BITREV_EN.

Verification
REQ-028 LOG2N=6, ready=1, start pulse at cycle 0 -> valid_o cycles 1..64, index_o 0..63, last_o at cycle 64 only, frame_cnt_o=1 at cycle 65, valid_o=0 at cycle 65.
REQ-029 ready low at cycles 10..14 -> index_o holds 9 during those cycles, completes 0..63 with no gap or duplicate, last_o at cycle 69.
REQ-030 start pulsed on the last-beat cycle -> index_o 63 followed by 0 next cycle, busy_o never drops, frame_cnt_o=2 after two frames.
REQ-031 start pulsed at index_o=20 -> overrun_o high exactly one cycle, sequence continues 21..63, frame_cnt_o +1 only.
REQ-032 rst at index_o=30 -> all outputs 0 next cycle, frame_cnt_o unchanged at 0; new start -> index_o 0.
REQ-033 FRAME_W=2, 5 frames -> frame_cnt_o 1,2,3,0,1; with FFT_OUTSEQ_BITREV_EN, index_o=1 -> addr_o=32, index_o=6 -> addr_o=24.
